// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and GF(2^8) / S-box helpers
package aes_pkg;

  localparam int NR = 10;
  localparam int BYTES = 16;
  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] LAST_BYTE = 4'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, KEYEXP, ROUND, OUTPUT} fsmState_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gfInv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return gfInv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] stateIn,
  input  logic [127:0] roundKey,
  input  logic         lastRound,
  output logic [127:0] stateOut
);

  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Byte i sits at [127-8i -: 8]; row r, column c is byte r+4c. Row r rotates right by r.
  always_comb begin
    logic [31:0] col;
    int src;
    stateOut = '0;
    for (int c = 0; c < 4; c++) begin
      col = '0;
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c - r) & 3);
        col[31-8*r -: 8] = invSbox(stateIn[127-8*src -: 8]) ^ roundKey[127-8*(r+4*c) -: 8];
      end
      stateOut[127-32*c -: 32] = lastRound ? col : invMixCol(col);
    end
  end

endmodule

// File: rtl/aes_decryption.sv
// rtl/aes_decryption.sv - byte-serial AES-128 inverse cipher with stored round keys
module aes_decryption
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] key_byte,
  input  logic [7:0] state_byte,
  output logic [7:0] state_out_byte,
  output logic       load,
  output logic       ready
);

  fsmState_t    fsm;
  logic [3:0]   byteCnt;
  logic [3:0]   roundCnt;
  logic [127:0] cstate;
  logic [127:0] state;
  logic [127:0] rk [0:10];
  logic [127:0] invNext;
  logic [3:0]   loadIdx;
  logic [3:0]   outIdx;
  logic         lastRound;

  function automatic logic [127:0] keyExpand(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rc, 24'h000000};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign loadIdx   = 4'd15 - byteCnt;
  assign outIdx    = 4'd14 - byteCnt;
  assign lastRound = (roundCnt == 4'd0);

  aes_inv_round uInvRound (
    .stateIn  (state),
    .roundKey (rk[roundCnt]),
    .lastRound(lastRound),
    .stateOut (invNext)
  );

  // The key is shifted straight into rk[0]; no separate key register is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm            <= IDLE;
      byteCnt        <= 4'd0;
      roundCnt       <= 4'd0;
      cstate         <= '0;
      state          <= '0;
      state_out_byte <= 8'h00;
      load           <= 1'b0;
      ready          <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (enable) begin
      case (fsm)
        IDLE: begin
          fsm     <= LOAD;
          load    <= 1'b1;
          byteCnt <= 4'd0;
        end
        LOAD: begin
          rk[0][{loadIdx, 3'b000} +: 8]  <= key_byte;
          cstate[{loadIdx, 3'b000} +: 8] <= state_byte;
          byteCnt <= byteCnt + 4'd1;
          if (byteCnt == LAST_BYTE) begin
            load     <= 1'b0;
            roundCnt <= 4'd1;
            fsm      <= KEYEXP;
          end
        end
        KEYEXP: begin
          rk[roundCnt] <= keyExpand(rk[roundCnt - 4'd1], rcon(roundCnt));
          if (roundCnt == LAST_ROUND) fsm <= ROUND;
          else roundCnt <= roundCnt + 4'd1;
        end
        ROUND: begin
          if (roundCnt == LAST_ROUND) state <= cstate ^ rk[LAST_ROUND];
          else state <= invNext;
          if (lastRound) begin
            fsm            <= OUTPUT;
            ready          <= 1'b1;
            state_out_byte <= invNext[127:120];
          end else begin
            roundCnt <= roundCnt - 4'd1;
          end
        end
        OUTPUT: begin
          byteCnt <= byteCnt + 4'd1;
          if (byteCnt == LAST_BYTE) begin
            ready <= 1'b0;
            fsm   <= IDLE;
          end else begin
            state_out_byte <= state[{outIdx, 3'b000} +: 8];
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
